master_in_port: RTL and testbench
=================================

Name: master_in_port

Overview:
- Master-side receive stage; sits directly downstream of the slave serial transmit port.
- Drives master_ready into that port's handshake.
- Deserializes the LSB-first bit stream (rx_data qualified by slave_valid, framed by slave_tx_done) into bytes.
- Buffers bytes in a small FWFT FIFO and presents them to master logic on a valid/ready interface.

Parameters:
- DATA_WIDTH, 8, bits per serial frame; slave_tx_done must coincide with the last bit.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  1  serial data bit from the slave port.
- slave_valid  in  1  slave port transmitting; qualifies rx_data.
- slave_tx_done  in  1  slave port last-bit marker, high with bit DATA_WIDTH-1.
- master_ready  out  1  receiver can accept a new frame; feeds the slave handshake.
- dout  out  DATA_WIDTH  FIFO head byte.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer pops head when high with dout_valid.
- rx_done  out  1  one-cycle pulse; byte written to FIFO.
- frame_err  out  1  one-cycle pulse; frame discarded.
- overflow  out  1  sticky; complete byte dropped because FIFO was full.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, bit_cnt=0, shift=0, FIFO empty, dout=0, dout_valid=0, rx_done=0, frame_err=0, overflow=0.
- master_ready is forced 0 while reset is high.
- master_ready = (occupancy + in_flight) < FIFO_DEPTH. It is decoded from registers only, with no input-to-output combinational path.
  - in_flight = 1 in RECV, else 0.
- Frame timing: the first valid bit arrives one cycle after the handshake cycle. Bits then follow on consecutive cycles.
- After the last bit, the upstream port holds slave_valid high for one stale cycle with a repeated rx_data. The GAP state swallows that cycle.
- States:
  - IDLE, slave_valid=1:
    - shift[0]<=rx_data, bit_cnt<=1, go RECV.
    - If slave_tx_done=1 in the same cycle: frame_err pulse, go GAP, nothing stored.
  - IDLE, slave_valid=0: hold.
  - RECV, slave_valid=1, bit_cnt<DATA_WIDTH-1:
    - shift[bit_cnt]<=rx_data, bit_cnt+1.
    - If slave_tx_done=1: early end; frame_err pulse, discard, bit_cnt<=0, go GAP.
  - RECV, slave_valid=1, bit_cnt=DATA_WIDTH-1:
    - The assembled byte is {rx_data, shift[DATA_WIDTH-2:0]}.
    - If slave_tx_done=1 and FIFO not full after this cycle's pop: push the byte, rx_done pulse.
    - If slave_tx_done=1 and FIFO full: drop the byte, set overflow.
    - If slave_tx_done=0: frame_err pulse, discard.
    - In all three cases bit_cnt<=0, go GAP.
  - RECV, slave_valid=0: aborted frame; frame_err pulse, discard, bit_cnt<=0, go IDLE.
  - GAP: ignore all serial inputs for exactly one cycle, go IDLE.
- Back-to-back frames: bit0 of the next frame arrives the cycle after GAP and is accepted from IDLE.
- Bit order: LSB first. dout[i] is the i-th valid bit received.
- FIFO:
  - First-word-fall-through: dout shows the head whenever dout_valid=1.
  - A write becomes visible on dout/dout_valid the cycle after the push.
  - Pop when dout_valid & dout_ready.
  - Simultaneous push and pop when full: allowed, occupancy unchanged.
  - Simultaneous push and pop when empty: the pop is ignored (dout_valid=0); the push lands.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Outputs: rx_done and frame_err are registered pulses, high the cycle after the triggering edge for one cycle. overflow clears only on reset.
- Reset mid-frame: partial byte lost, FIFO flushed, no pulses emitted. The receiver restarts in IDLE.

Test Plan:
- Single byte 0xA5: handshake, then bits 1,0,1,0,0,1,0,1 with slave_tx_done on the 8th bit and a stale valid cycle; dout_ready=1.
  -> rx_done pulses once, dout=0xA5 with dout_valid the cycle after the push, exactly one pop, no frame_err.
- Back-to-back 0x01, 0x80, 0xFF with no idle cycles beyond the GAP cycle, dout_ready=1.
  -> three rx_done pulses, dout sequence 0x01, 0x80, 0xFF; the stale cycles never create a ninth bit.
- Full FIFO: four bytes 0x11..0x44 with dout_ready=0.
  -> master_ready goes 0 once occupancy + in_flight = 4 (from the 4th frame's RECV onward).
  -> master_ready returns to 1 the cycle after the first pop; pops return 0x11..0x44 in order.
- Forced overflow: the bench ignores master_ready and sends a 5th byte 0x55 into the full FIFO.
  -> overflow=1 and stays set, 0x55 absent, FIFO contents unchanged.
- Framing faults:
  - slave_valid drops after 4 bits -> frame_err pulse, no push, back to IDLE.
  - slave_tx_done on bit 3 -> frame_err pulse, no push.
  - the next clean frame 0x3C is received correctly.
- reset asserted asynchronously mid-frame after 5 bits and with 2 bytes queued.
  -> immediately master_ready=0, dout_valid=0.
  -> after release: master_ready=1, FIFO empty, the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/master_in_port.sv
`default_nettype none
// ============================================================================
// Module   : master_in_port
// Purpose  : Master-side receive stage. Handshakes with the slave serial
//            transmit port through master_ready, deserialises the LSB-first
//            bit stream into DATA_WIDTH-bit words and queues them in a small
//            first-word-fall-through FIFO read out over valid/ready.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           system clock, rising edge
//   reset          in   1           asynchronous, active-high reset
//   rx_data        in   1           serial data bit from the slave port
//   slave_valid    in   1           slave port transmitting, qualifies rx_data
//   slave_tx_done  in   1           last-bit marker, high with bit DATA_WIDTH-1
//   master_ready   out  1           room for one more complete frame
//   dout           out  DATA_WIDTH  FIFO head word (0 while empty)
//   dout_valid     out  1           FIFO non-empty
//   dout_ready     in   1           consumer pops the head when dout_valid=1
//   rx_done        out  1           one-cycle pulse, word written to the FIFO
//   frame_err      out  1           one-cycle pulse, frame discarded
//   overflow       out  1           sticky, complete word dropped (FIFO full)
// ============================================================================
module master_in_port #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_data,
    input  logic                  slave_valid,
    input  logic                  slave_tx_done,
    output logic                  master_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(FIFO_DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    // Receiver states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RECV = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_count;
    logic                  r_rx_done;
    logic                  r_frame_err;
    logic                  r_overflow;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_shift_we;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_ferr;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_in_flight;
    logic [c_OCC_W-1:0]    w_occ_sum;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_full      = (r_count == c_DEPTH);
    assign dout_valid  = (r_count != '0);
    assign w_pop       = dout_valid & dout_ready;
    assign w_in_flight = (r_state == c_ST_RECV);

    // A frame being received has already claimed a FIFO slot, so it counts
    // toward occupancy when deciding whether to invite another frame. The
    // sum cannot overflow: c_OCC_W bits hold up to 2*FIFO_DEPTH-1.
    assign w_occ_sum    = r_count + (w_in_flight ? c_OCC_ONE : '0);
    assign master_ready = ~reset & (w_occ_sum < c_DEPTH);

    // The final bit is taken straight from the line; it never enters r_shift.
    assign w_word = {rx_data, r_shift[DATA_WIDTH-2:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_we  = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (slave_valid) begin
                    if (slave_tx_done) begin
                        // A one-bit frame cannot be a complete word.
                        w_ferr      = 1'b1;
                        w_state_nxt = c_ST_GAP;
                    end else begin
                        // r_bit_cnt is 0 in IDLE, so this writes bit 0.
                        w_shift_we  = 1'b1;
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = c_ST_RECV;
                    end
                end
            end
            c_ST_RECV: begin
                if (!slave_valid) begin
                    w_ferr      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_bit_cnt != c_LAST_BIT) begin
                    if (slave_tx_done) begin
                        w_ferr      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_GAP;
                    end else begin
                        w_shift_we = 1'b1;
                        w_cnt_nxt  = r_bit_cnt + c_CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_GAP;
                    if (slave_tx_done) begin
                        // A same-cycle pop frees the slot this push needs.
                        if (!w_full || w_pop) begin
                            w_push = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            c_ST_GAP: begin
                // Swallow the stale repeat cycle the slave port emits after
                // its last bit.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Receiver state, shift register and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_rx_done   <= w_push;
            r_frame_err <= w_ferr;
            if (w_shift_we) begin
                r_shift[r_bit_cnt] <= rx_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control: pointers wrap naturally because FIFO_DEPTH is a power
    // of two. A pop with an empty FIFO cannot occur since w_pop requires
    // dout_valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: every readable entry was written first.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Head is masked while empty so dout reads 0 after reset and after the
    // last pop instead of showing stale storage.
    assign dout      = dout_valid ? r_mem[r_rd_ptr] : '0;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_master_in_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_in_port
// Purpose  : Directed self-checking bench for master_in_port. Inputs change
//            1 time unit after each rising edge; outputs are sampled there.
// Revision : 1.0  initial release
// ============================================================================
module tb_master_in_port;

    logic       clk           = 1'b0;
    logic       reset         = 1'b1;
    logic       rx_data       = 1'b0;
    logic       slave_valid   = 1'b0;
    logic       slave_tx_done = 1'b0;
    logic       dout_ready    = 1'b0;
    logic       master_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    master_in_port #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .slave_valid   (slave_valid),
        .slave_tx_done (slave_tx_done),
        .master_ready  (master_ready),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .rx_done       (rx_done),
        .frame_err     (frame_err),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the serial line quiet (handshake / idle cycle).
    task automatic idle_cycle();
        slave_valid   = 1'b0;
        slave_tx_done = 1'b0;
        rx_data       = 1'b0;
        tick();
    endtask

    // Drive bits first..last of b, slave_tx_done high on bit done_at.
    task automatic send_bits(input logic [7:0] b, input int first, input int last, input int done_at);
        for (int i = first; i <= last; i++) begin
            rx_data       = b[i];
            slave_valid   = 1'b1;
            slave_tx_done = (i == done_at);
            tick();
        end
    endtask

    // Stale repeat cycle after the last bit, then release the line.
    task automatic stale(input logic [7:0] b);
        rx_data       = b[7];
        slave_valid   = 1'b1;
        slave_tx_done = 1'b0;
        tick();
        slave_valid   = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        check("ready_in_reset", master_ready, 0);
        reset = 1'b0;
        tick();
        check("rst_ready", master_ready, 1);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_rx_done", rx_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);

        // ---------------- single byte 0xA5 ----------------
        dout_ready = 1'b1;
        idle_cycle();
        send_bits(8'hA5, 0, 6, 99);
        check("a5_ready_recv", master_ready, 1);
        send_bits(8'hA5, 7, 7, 7);
        check("a5_rx_done", rx_done, 1);
        check("a5_dout_valid", dout_valid, 1);
        check("a5_dout", dout, 8'hA5);
        check("a5_no_ferr", frame_err, 0);
        stale(8'hA5);
        check("a5_rx_done_low", rx_done, 0);
        check("a5_single_pop", dout_valid, 0);

        // ---------------- back-to-back 01, 80, FF ----------------
        idle_cycle();
        send_bits(8'h01, 0, 7, 7);
        check("b2b_01_done", rx_done, 1);
        check("b2b_01", dout, 8'h01);
        stale(8'h01);
        send_bits(8'h80, 0, 7, 7);
        check("b2b_80_done", rx_done, 1);
        check("b2b_80", dout, 8'h80);
        stale(8'h80);
        send_bits(8'hFF, 0, 7, 7);
        check("b2b_ff_done", rx_done, 1);
        check("b2b_ff", dout, 8'hFF);
        check("b2b_no_ferr", frame_err, 0);
        stale(8'hFF);
        check("b2b_drained", dout_valid, 0);

        // ---------------- fill FIFO 11..44 ----------------
        dout_ready = 1'b0;
        idle_cycle(); send_bits(8'h11, 0, 7, 7); stale(8'h11);
        idle_cycle(); send_bits(8'h22, 0, 7, 7); stale(8'h22);
        idle_cycle(); send_bits(8'h33, 0, 7, 7); stale(8'h33);
        idle_cycle();
        check("fill_ready_occ3_idle", master_ready, 1);
        send_bits(8'h44, 0, 0, 99);
        check("fill_ready_occ3_recv", master_ready, 0);
        send_bits(8'h44, 1, 7, 7);
        check("fill_44_done", rx_done, 1);
        stale(8'h44);
        check("fill_ready_full", master_ready, 0);
        check("fill_head", dout, 8'h11);

        // ---------------- forced overflow with 0x55 ----------------
        idle_cycle();
        send_bits(8'h55, 0, 7, 7);
        check("ovf_set", overflow, 1);
        check("ovf_no_rx_done", rx_done, 0);
        check("ovf_head_kept", dout, 8'h11);
        stale(8'h55);
        check("ovf_sticky", overflow, 1);

        // ---------------- drain ----------------
        dout_ready = 1'b1;
        tick();
        check("drain_ready_back", master_ready, 1);
        check("drain_22", dout, 8'h22);
        tick();
        check("drain_33", dout, 8'h33);
        tick();
        check("drain_44", dout, 8'h44);
        tick();
        check("drain_empty", dout_valid, 0);
        check("drain_ovf_sticky", overflow, 1);

        // ---------------- framing faults ----------------
        idle_cycle();
        send_bits(8'hF0, 0, 3, 99);
        idle_cycle();
        check("abort_ferr", frame_err, 1);
        check("abort_no_push", dout_valid, 0);
        idle_cycle();
        check("abort_ferr_pulse", frame_err, 0);

        send_bits(8'h0F, 0, 3, 3);
        check("early_ferr", frame_err, 1);
        check("early_no_done", rx_done, 0);
        idle_cycle();
        check("early_no_push", dout_valid, 0);

        idle_cycle();
        send_bits(8'h3C, 0, 7, 7);
        check("clean_3c_done", rx_done, 1);
        check("clean_3c", dout, 8'h3C);
        check("clean_3c_no_ferr", frame_err, 0);
        stale(8'h3C);

        // ---------------- reset mid-frame ----------------
        dout_ready = 1'b0;
        idle_cycle(); send_bits(8'h12, 0, 7, 7); stale(8'h12);
        idle_cycle(); send_bits(8'h34, 0, 7, 7); stale(8'h34);
        idle_cycle();
        send_bits(8'h9A, 0, 4, 99);
        check("pre_rst_valid", dout_valid, 1);
        reset       = 1'b1;
        slave_valid = 1'b0;
        #1;
        check("async_rst_ready", master_ready, 0);
        check("async_rst_valid", dout_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", master_ready, 1);
        check("post_rst_empty", dout_valid, 0);
        check("post_rst_no_ferr", frame_err, 0);
        check("post_rst_ovf_clr", overflow, 0);

        dout_ready = 1'b1;
        idle_cycle();
        send_bits(8'hC3, 0, 7, 7);
        check("post_rst_c3_done", rx_done, 1);
        check("post_rst_c3", dout, 8'hC3);
        stale(8'hC3);
        check("post_rst_drained", dout_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
